// File: rtl/l1_dcache_if.sv
// Core-side data-cache port: the MEM stage drives requests, the cache answers
// with load data and a stall that holds the pipeline until service completes.
interface l1_dcache_if #(
  parameter int data_size = 32,
  parameter int mem_size  = 16
);
  logic [mem_size-1:0]  DC_Address;
  logic                 DC_Read_enable;
  logic                 DC_Write_enable;
  logic [data_size-1:0] DC_Write_Data;
  logic [data_size-1:0] DC_Read_Data;
  logic                 DC_stall;

  modport master (
    output DC_Address, DC_Read_enable, DC_Write_enable, DC_Write_Data,
    input  DC_Read_Data, DC_stall
  );

  modport slave (
    input  DC_Address, DC_Read_enable, DC_Write_enable, DC_Write_Data,
    output DC_Read_Data, DC_stall
  );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, one-word-line, write-through, no-write-allocate L1 data cache.
// Loads that hit return data in the same cycle; misses and all stores go to
// the backing memory through a registered request / one-cycle ready handshake.
module l1_dcache #(
  parameter int data_size = 32,
  parameter int mem_size  = 16,
  parameter int idx_size  = 6,
  parameter int cnt_size  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  l1_dcache_if.slave           dc,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [mem_size-1:0]  mem_addr,
  output logic [data_size-1:0] mem_wdata,
  input  logic [data_size-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [cnt_size-1:0]  hit_count,
  output logic [cnt_size-1:0]  miss_count
);

  localparam int tag_size = mem_size - idx_size;
  localparam int lines    = 1 << idx_size;

  typedef enum logic [1:0] {IDLE, RMISS, WMEM, WDONE} state_t;

  state_t state, next_state;

  logic [lines-1:0]     valid;
  logic [tag_size-1:0]  tag_array  [lines];
  logic [data_size-1:0] data_array [lines];

  logic [idx_size-1:0] req_idx;
  logic [tag_size-1:0] req_tag;
  logic                req_hit;
  logic [idx_size-1:0] svc_idx;
  logic [tag_size-1:0] svc_tag;
  logic                svc_hit;
  logic                load_req;

  // The request being serviced is taken from the latched mem_addr, so the
  // fill/update never depends on the core keeping its address stable.
  assign req_idx  = dc.DC_Address[idx_size-1:0];
  assign req_tag  = dc.DC_Address[mem_size-1:idx_size];
  assign req_hit  = valid[req_idx] && (tag_array[req_idx] == req_tag);
  assign svc_idx  = mem_addr[idx_size-1:0];
  assign svc_tag  = mem_addr[mem_size-1:idx_size];
  assign svc_hit  = valid[svc_idx] && (tag_array[svc_idx] == svc_tag);
  assign load_req = dc.DC_Read_enable && !dc.DC_Write_enable;

  // State register; reset abandons whatever transaction is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state selection; stores win over loads when both are requested.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (dc.DC_Write_enable)            next_state = WMEM;
        else if (load_req && !req_hit)     next_state = RMISS;
      end
      RMISS:   if (mem_ready) next_state = IDLE;
      WMEM:    if (mem_ready) next_state = WDONE;
      WDONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Core-facing outputs: stall is combinational and forced low during reset.
  always_comb begin
    dc.DC_stall     = 1'b0;
    dc.DC_Read_Data = data_array[req_idx];
    case (state)
      IDLE:    dc.DC_stall = dc.DC_Write_enable || (dc.DC_Read_enable && !req_hit);
      RMISS:   dc.DC_stall = 1'b1;
      WMEM:    dc.DC_stall = 1'b1;
      WDONE:   dc.DC_stall = 1'b0;
      default: dc.DC_stall = 1'b0;
    endcase
    if (!rst) begin
      dc.DC_stall     = 1'b0;
      dc.DC_Read_Data = '0;
    end
  end

  // Registered memory request; launched from IDLE, dropped on mem_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dc.DC_Write_enable) begin
            mem_write <= 1'b1;
            mem_addr  <= dc.DC_Address;
            mem_wdata <= dc.DC_Write_Data;
          end else if (load_req && !req_hit) begin
            mem_read <= 1'b1;
            mem_addr <= dc.DC_Address;
          end
        end
        RMISS:   if (mem_ready) mem_read  <= 1'b0;
        WMEM:    if (mem_ready) mem_write <= 1'b0;
        default: ;
      endcase
    end
  end

  // Valid bits are the only line state that needs clearing on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                            valid <= '0;
    else if (state == RMISS && mem_ready) valid[svc_idx] <= 1'b1;
  end

  // Tag/data storage: fill on a completed read, update only on a store hit.
  always_ff @(posedge clk) begin
    if (state == RMISS && mem_ready) begin
      tag_array[svc_idx]  <= svc_tag;
      data_array[svc_idx] <= mem_rdata;
    end else if (state == WMEM && mem_ready && svc_hit) begin
      data_array[svc_idx] <= mem_wdata;
    end
  end

  // Saturating load hit/miss statistics, counted when a load is seen in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE && load_req) begin
      if (req_hit) begin
        if (hit_count != {cnt_size{1'b1}}) hit_count <= hit_count + 1'b1;
      end else begin
        if (miss_count != {cnt_size{1'b1}}) miss_count <= miss_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed bench for l1_dcache with a small backing-memory model that answers
// each request a fixed number of cycles after it first sees it.
module tb_l1_dcache;
  localparam int data_size = 32;
  localparam int mem_size  = 16;
  localparam int idx_size  = 6;
  localparam int cnt_size  = 16;
  localparam int mem_lat   = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 mem_read, mem_write;
  logic [mem_size-1:0]  mem_addr;
  logic [data_size-1:0] mem_wdata;
  logic [data_size-1:0] mem_rdata;
  logic                 mem_ready;
  logic [cnt_size-1:0]  hit_count, miss_count;

  logic [data_size-1:0] mem_model [0:65535];
  int wait_cnt = 0;
  int errors = 0;
  int checks = 0;

  l1_dcache_if #(.data_size(data_size), .mem_size(mem_size)) dc_bus ();

  l1_dcache #(
    .data_size(data_size), .mem_size(mem_size),
    .idx_size(idx_size), .cnt_size(cnt_size)
  ) dut (
    .clk(clk), .rst(rst), .dc(dc_bus),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
    dc_bus.DC_Read_enable  = rd;
    dc_bus.DC_Write_enable = wr;
    dc_bus.DC_Address      = addr;
    dc_bus.DC_Write_Data   = wdata;
  endtask

  // Memory responder: ready pulses mem_lat cycles after the request first shows up.
  task automatic serviceMemory();
    if (mem_ready) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else if (mem_read || mem_write) begin
      if (wait_cnt == mem_lat) begin
        mem_ready = 1'b1;
        if (mem_write) mem_model[mem_addr] = mem_wdata;
        else           mem_rdata = mem_model[mem_addr];
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    serviceMemory();
  endtask

  task automatic runLoad(input string tag, input logic [15:0] addr, input logic [31:0] exp_data, input int exp_stalls);
    int stalls = 0;
    applyStimulus(1'b1, 1'b0, addr, 32'h0);
    #1;
    while (dc_bus.DC_stall === 1'b1 && stalls < 50) begin
      stalls++;
      tick();
      #1;
    end
    checkOutput({tag, "_stalls"}, stalls, exp_stalls);
    checkOutput({tag, "_data"}, dc_bus.DC_Read_Data, exp_data);
    tick();
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic runStore(input string tag, input logic rd, input logic [15:0] addr, input logic [31:0] data);
    int stalls = 1;
    applyStimulus(rd, 1'b1, addr, data);
    #1;
    checkOutput({tag, "_stall0"}, dc_bus.DC_stall, 1);
    tick();
    #1;
    checkOutput({tag, "_mwrite"}, mem_write, 1);
    checkOutput({tag, "_mread"}, mem_read, 0);
    checkOutput({tag, "_maddr"}, mem_addr, addr);
    checkOutput({tag, "_mwdata"}, mem_wdata, data);
    while (dc_bus.DC_stall === 1'b1 && stalls < 50) begin
      stalls++;
      tick();
      #1;
    end
    checkOutput({tag, "_stalls"}, stalls, mem_lat + 2);
    checkOutput({tag, "_wdone_mwrite"}, mem_write, 0);
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
    tick();
    #1;
    checkOutput({tag, "_idle_stall"}, dc_bus.DC_stall, 0);
  endtask

  // Main directed sequence.
  initial begin
    applyStimulus(1'b1, 1'b1, 16'h0041, 32'h0);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    mem_model[16'h0000] = 32'h0000AAAA;
    mem_model[16'h0041] = 32'hDEADBEEF;
    mem_model[16'h0081] = 32'hCAFEF00D;
    mem_model[16'h0200] = 32'h0BADF00D;
    mem_model[16'h0010] = 32'h77777777;

    #2;
    checkOutput("rst_stall", dc_bus.DC_stall, 0);
    checkOutput("rst_rdata", dc_bus.DC_Read_Data, 0);
    checkOutput("rst_mread", mem_read, 0);
    checkOutput("rst_mwrite", mem_write, 0);
    checkOutput("rst_maddr", mem_addr, 0);
    checkOutput("rst_mwdata", mem_wdata, 0);
    checkOutput("rst_hits", hit_count, 0);
    checkOutput("rst_misses", miss_count, 0);
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();

    $display("[TB] cold miss, then hit");
    runLoad("ld41a", 16'h0041, 32'hDEADBEEF, mem_lat + 2);
    checkOutput("ld41a_miss", miss_count, 1);
    checkOutput("ld41a_hit", hit_count, 1);
    runLoad("ld41b", 16'h0041, 32'hDEADBEEF, 0);
    checkOutput("ld41b_hit", hit_count, 2);
    checkOutput("ld41b_mread", mem_read, 0);

    $display("[TB] conflict replacement on index 1");
    runLoad("ld81a", 16'h0081, 32'hCAFEF00D, mem_lat + 2);
    runLoad("ld41c", 16'h0041, 32'hDEADBEEF, mem_lat + 2);
    checkOutput("ld41c_miss", miss_count, 3);
    runLoad("ld81b", 16'h0081, 32'hCAFEF00D, mem_lat + 2);
    checkOutput("ld81b_miss", miss_count, 4);
    checkOutput("ld81b_hit", hit_count, 5);

    $display("[TB] store hit updates line, store miss does not allocate");
    runStore("st81", 1'b0, 16'h0081, 32'h12345678);
    checkOutput("st81_mem", mem_model[16'h0081], 32'h12345678);
    runLoad("ld81c", 16'h0081, 32'h12345678, 0);
    checkOutput("ld81c_hit", hit_count, 6);
    runStore("st200", 1'b0, 16'h0200, 32'h55AA55AA);
    checkOutput("st200_mem", mem_model[16'h0200], 32'h55AA55AA);
    runLoad("ld200a", 16'h0200, 32'h55AA55AA, mem_lat + 2);
    checkOutput("ld200a_miss", miss_count, 5);
    checkOutput("ld200a_hit", hit_count, 7);

    $display("[TB] reset during a read miss");
    applyStimulus(1'b1, 1'b0, 16'h0041, 32'h0);
    #1;
    checkOutput("rm_stall", dc_bus.DC_stall, 1);
    tick();
    #1;
    checkOutput("rm_mread", mem_read, 1);
    rst = 1'b0;
    #1;
    checkOutput("rm_rst_mread", mem_read, 0);
    checkOutput("rm_rst_stall", dc_bus.DC_stall, 0);
    checkOutput("rm_rst_miss", miss_count, 0);
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);
    mem_ready = 1'b0;
    wait_cnt  = 0;
    tick();
    rst = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h11111111;
    tick();
    #1;
    checkOutput("late_ready_stall", dc_bus.DC_stall, 0);
    checkOutput("late_ready_mread", mem_read, 0);
    runLoad("post41", 16'h0041, 32'hDEADBEEF, mem_lat + 2);
    runLoad("post200", 16'h0200, 32'h55AA55AA, mem_lat + 2);
    runLoad("post000", 16'h0000, 32'h0000AAAA, mem_lat + 2);
    checkOutput("post_miss", miss_count, 3);
    checkOutput("post_hit", hit_count, 3);

    $display("[TB] both enables: store wins, no fill");
    runStore("both10", 1'b1, 16'h0010, 32'hA5A5A5A5);
    checkOutput("both10_mem", mem_model[16'h0010], 32'hA5A5A5A5);
    checkOutput("both10_miss", miss_count, 3);
    runLoad("ld10", 16'h0010, 32'hA5A5A5A5, mem_lat + 2);
    checkOutput("ld10_miss", miss_count, 4);
    checkOutput("ld10_hit", hit_count, 4);

    $display("[TB] hit counter saturation");
    applyStimulus(1'b1, 1'b0, 16'h0010, 32'h0);
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("sat_hit", hit_count, 32'h0000FFFF);
    checkOutput("sat_miss", miss_count, 4);
    checkOutput("sat_stall", dc_bus.DC_stall, 0);
    checkOutput("sat_data", dc_bus.DC_Read_Data, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    checkOutput("sat_hold", hit_count, 32'h0000FFFF);
    applyStimulus(1'b0, 1'b0, 16'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/l1_dcache.md
Name: l1_dcache

Overview:
- Responder end of the core's data-cache interface.
- Accepts word-addressed load/store requests from the MEM stage.
- Returns read data, and holds the pipeline through `DC_stall` until each request is serviced.
- Direct-mapped, one-word lines, write-through, no-write-allocate. Sits between the core and the backing data memory, which is reached through a request/ready handshake.

Parameters:
- `data_size`, 32, data word width.
- `mem_size`, 16, word-address width.
- `idx_size`, 6, index bits; line count = 2^idx_size (64).
- `cnt_size`, 16, width of the hit/miss statistics counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `DC_Address`  in  mem_size  word address from the core.
- `DC_Read_enable`  in  1  load request.
- `DC_Write_enable`  in  1  store request.
- `DC_Write_Data`  in  data_size  store data.
- `DC_Read_Data`  out  data_size  load data; valid when `DC_stall`=0 and `DC_Read_enable`=1.
- `DC_stall`  out  1  hold pipeline; combinational.
- `mem_read`  out  1  memory read request; registered.
- `mem_write`  out  1  memory write request; registered.
- `mem_addr`  out  mem_size  memory word address; registered.
- `mem_wdata`  out  data_size  memory write data; registered.
- `mem_rdata`  in  data_size  memory read data; valid when `mem_ready`=1.
- `mem_ready`  in  1  one-cycle completion pulse for the current request.
- `hit_count`  out  cnt_size  load hits; saturating.
- `miss_count`  out  cnt_size  load misses; saturating.

Behaviour:
- Address split:
  - index = `DC_Address[idx_size-1:0]`
  - tag = `DC_Address[mem_size-1:idx_size]`
  - each line holds valid, tag and data.
- hit = `valid[index]` && (`tag_array[index]` == tag).
- Reset (`rst`=0, asynchronous):
  - state=IDLE, all valid bits=0.
  - `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
  - Counters=0. `DC_stall` forced 0. `DC_Read_Data`=0.
  - Reset mid-transaction abandons the memory request immediately; a late `mem_ready` in IDLE is ignored.
- States: IDLE, RMISS, WMEM, WDONE.
- IDLE:
  - `DC_Write_enable`=1 (takes priority if both enables set): `DC_stall`=1. Next cycle: WMEM, with `mem_write`=1, `mem_addr`=`DC_Address`, `mem_wdata`=`DC_Write_Data`.
  - Else `DC_Read_enable`=1 and hit: `DC_stall`=0, `DC_Read_Data`=line data (same cycle, combinational). `hit_count`+1 at the edge.
  - Else `DC_Read_enable`=1 and miss: `DC_stall`=1. Next cycle: RMISS, with `mem_read`=1 and `mem_addr` latched. `miss_count`+1.
  - No request: `DC_stall`=0, `DC_Read_Data` = data of the indexed line (don't-care).
- RMISS:
  - `DC_stall`=1; request held stable until `mem_ready`.
  - On `mem_ready`=1: line[index] ← {valid=1, tag, `mem_rdata`}; `mem_read`←0; next state IDLE.
  - In IDLE the load now hits: stall drops and data is delivered. That access also counts as a hit.
  - Load miss penalty = memory latency + 2 cycles.
- WMEM:
  - `DC_stall`=1; request held until `mem_ready`.
  - On `mem_ready`=1: `mem_write`←0. If the line is a hit (valid and tag match), line data ← `mem_wdata`; a miss leaves the line untouched (no allocate). Next state WDONE.
- WDONE:
  - `DC_stall`=0 for exactly one cycle so the store retires; next state IDLE.
  - If the core is still held by the instruction-cache stall, the store re-presents in IDLE and is re-issued. This is idempotent and permitted.
- `mem_read` and `mem_write` are never both 1.
- A request seen in RMISS/WMEM/WDONE other than the one in service is not accepted. The core holds its MEM stage while stalled.
- Counters saturate at all-ones and never wrap.
- A `mem_ready` received while `mem_read`=`mem_write`=0 is ignored.

Test Plan:
- Reset, then load addr 0x0041 (memory returns 0xDEADBEEF after 3 cycles) → `DC_stall`=1 for 5 cycles, then `DC_Read_Data`=0xDEADBEEF with stall 0; `miss_count`=1, `hit_count`=1.
- Repeat load 0x0041 → no stall, data 0xDEADBEEF same cycle, `hit_count`=2, no `mem_read`.
- Load 0x0081 (same index, different tag) after 0x0041 → miss, line replaced. A subsequent load of 0x0041 misses again (`miss_count`=3).
- Store 0x12345678 to cached 0x0081 → `mem_write`=1 with correct `mem_addr`/`mem_wdata`, one-cycle stall release in WDONE, then load 0x0081 hits with 0x12345678. Store to uncached 0x0200 → memory written, load 0x0200 misses.
- Assert `rst`=0 during RMISS → `mem_read` drops asynchronously, all lines invalid, `DC_stall`=0. A later `mem_ready` pulse in IDLE causes no fill.
- Both enables high at 0x0010 → write serviced, no read fill; force 2^16 hits → `hit_count` holds 0xFFFF.
